pic_int_sequencer: RTL

//  Synchronous 8259-style interrupt sequencer that sits between the IRR and the CPU bus.
//  It resolves priority over the unmasked IRR and raises INT. It also runs the two-pulse

---
 rtl/pic_int_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pic_int_sequencer.sv
// -----------------------------------------------------------------------------
// pic_int_sequencer
//   8259-style interrupt sequencer between the IRR and the CPU bus. It picks the
//   highest-priority unmasked request that outranks everything in service,
//   raises INT, runs the two-pulse INTA handshake, hands the acknowledged level
//   back to the IRR, and owns the ISR, EOI handling and priority rotation.
//
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   irr, imr           latched requests; mask (1 = masked)
//   inta_n             CPU acknowledge, active-low, synchronous to clk
//   auto_eoi           clear the ISR bit at the end of the 2nd INTA
//   rotate_aeoi        rotate priority on auto-EOI
//   eoi_ns, eoi_sp     one-cycle EOI pulses: non-specific / specific
//   eoi_level          level cleared by eoi_sp
//   eoi_rotate         make the cleared level the lowest priority
//   vector_base        T7..T3 of the vector byte
//   INT                interrupt request to the CPU
//   irr_highest_bit    one-hot level being acknowledged, to the IRR
//   reset_irr_bit      one-cycle pulse: IRR clears irr_highest_bit
//   number_of_ack      INTA pulses seen in the current sequence
//   isr                in-service register
//   data_out, data_oe  vector byte and its bus drive enable
// -----------------------------------------------------------------------------
module pic_int_sequencer #(
  parameter int NUM_IR     = 8,
  parameter int LEVEL_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IR-1:0]     irr,
  input  logic [NUM_IR-1:0]     imr,
  input  logic                  inta_n,
  input  logic                  auto_eoi,
  input  logic                  rotate_aeoi,
  input  logic                  eoi_ns,
  input  logic                  eoi_sp,
  input  logic [LEVEL_BITS-1:0] eoi_level,
  input  logic                  eoi_rotate,
  input  logic [4:0]            vector_base,
  output logic                  INT,
  output logic [NUM_IR-1:0]     irr_highest_bit,
  output logic                  reset_irr_bit,
  output logic [1:0]            number_of_ack,
  output logic [NUM_IR-1:0]     isr,
  output logic [7:0]            data_out,
  output logic                  data_oe
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK1, S_ACK2} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_inta_d;
  logic [NUM_IR-1:0]     r_isr;
  logic [LEVEL_BITS-1:0] r_lowest;
  logic [LEVEL_BITS-1:0] r_level;
  logic                  r_spurious;
  logic [NUM_IR-1:0]     r_irr_hb;
  logic                  r_reset_irr;

  logic                  w_fall, w_rise;
  logic [NUM_IR-1:0]     w_req;
  logic                  w_cand_v, w_isr_any, w_cand_ok;
  logic [LEVEL_BITS-1:0] w_cand, w_isr_top;
  logic                  w_take, w_done;
  logic [NUM_IR-1:0]     w_isr_set, w_isr_clr;
  logic                  w_eoi_hit, w_aeoi;
  logic [LEVEL_BITS-1:0] w_eoi_lvl;

  // First set bit in rotating scan order, which starts just above 'lowest'
  // and wraps. Returns {found, level}.
  function automatic logic [LEVEL_BITS:0] first_set(input logic [NUM_IR-1:0]     bits,
                                                    input logic [LEVEL_BITS-1:0] lowest);
    logic [LEVEL_BITS:0]   res;
    logic [LEVEL_BITS-1:0] idx;
    res = '0;
    // Walk from lowest to highest priority so the highest one is written last.
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      idx = lowest + LEVEL_BITS'(i + 1);
      if (bits[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Position in scan order; 0 is the highest priority.
  function automatic logic [LEVEL_BITS-1:0] rank(input logic [LEVEL_BITS-1:0] lvl,
                                                 input logic [LEVEL_BITS-1:0] lowest);
    return lvl - lowest - LEVEL_BITS'(1);
  endfunction

  assign w_fall = r_inta_d & ~inta_n;
  assign w_rise = ~r_inta_d & inta_n;
  assign w_req  = irr & ~imr;

  assign {w_cand_v, w_cand}     = first_set(w_req, r_lowest);
  assign {w_isr_any, w_isr_top} = first_set(r_isr, r_lowest);

  // A request only counts if it strictly outranks the highest level in service.
  assign w_cand_ok = w_cand_v &&
                     (!w_isr_any || (rank(w_cand, r_lowest) < rank(w_isr_top, r_lowest)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that existed before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_take        = 1'b0;
    w_done        = 1'b0;
    INT           = 1'b0;
    number_of_ack = 2'd0;
    data_oe       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cand_ok) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // INT stays up even if the candidate vanishes; that becomes spurious.
        INT = 1'b1;
        if (w_fall) begin
          w_state_nxt = S_ACK1;
          w_take      = 1'b1;
        end
      end
      S_ACK1: begin
        number_of_ack = 2'd1;
        // A fall needs inta_d high, and inta_d was cleared on entry, so any
        // fall seen here already implies the intervening rise.
        if (w_fall) w_state_nxt = S_ACK2;
      end
      S_ACK2: begin
        number_of_ack = 2'd2;
        data_oe       = ~inta_n;
        if (w_rise) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_isr_set = '0;
    if (w_take && w_cand_ok) w_isr_set[w_cand] = 1'b1;

    w_eoi_hit = 1'b0;
    w_eoi_lvl = '0;
    if (eoi_sp) begin
      w_eoi_lvl = eoi_level;
      w_eoi_hit = r_isr[eoi_level];
    end else if (eoi_ns) begin
      w_eoi_lvl = w_isr_top;
      w_eoi_hit = w_isr_any;
    end
    // A bit being set this cycle survives an EOI aimed at it.
    if (w_isr_set[w_eoi_lvl]) w_eoi_hit = 1'b0;

    w_aeoi    = w_done && auto_eoi && !r_spurious;
    w_isr_clr = '0;
    if (w_eoi_hit) w_isr_clr[w_eoi_lvl] = 1'b1;
    if (w_aeoi)    w_isr_clr[r_level]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inta_d    <= 1'b1;
      r_isr       <= '0;
      r_lowest    <= '1;
      r_level     <= '0;
      r_spurious  <= 1'b0;
      r_irr_hb    <= '0;
      r_reset_irr <= 1'b0;
    end else begin
      r_inta_d    <= inta_n;
      r_isr       <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_reset_irr <= w_take && w_cand_ok;

      // irr_highest_bit is held for the whole handshake; the IRR depends on it.
      if (w_take) begin
        if (w_cand_ok) begin
          r_irr_hb   <= NUM_IR'(1) << w_cand;
          r_level    <= w_cand;
          r_spurious <= 1'b0;
        end else begin
          r_irr_hb   <= NUM_IR'(1) << (NUM_IR - 1);
          r_level    <= '1;
          r_spurious <= 1'b1;
        end
      end else if (w_done) begin
        r_irr_hb <= '0;
      end

      if (w_eoi_hit && eoi_rotate)     r_lowest <= w_eoi_lvl;
      else if (w_aeoi && rotate_aeoi)  r_lowest <= r_level;
    end
  end

  assign irr_highest_bit = r_irr_hb;
  assign reset_irr_bit   = r_reset_irr;
  assign isr             = r_isr;
  assign data_out        = data_oe ? {vector_base, r_level} : 8'h00;

endmodule
